// File: rtl/core_common.sv
// Shared definitions for the core timer block.
// Holds the MMIO register offsets and the access-controller state encoding.
package core_common;

    localparam logic [4:0] MTIMER_ADDR_MTIME    = 5'h00;
    localparam logic [4:0] MTIMER_ADDR_MTIMECMP = 5'h08;
    localparam logic [4:0] MTIMER_ADDR_MSIP     = 5'h10;
    localparam logic [4:0] MTIMER_ADDR_RSVD     = 5'h18;

    typedef enum logic {
        MTIMER_IDLE = 1'b0,
        MTIMER_RESP = 1'b1
    } mtimer_state_t;

endpackage

// File: rtl/core_mtimer_prescale.sv
// Prescaler for mtime: counts 0..PRESCALE-1 while enabled and emits a
// one-cycle tick on the last count, then wraps.
// Ports:
//   g_clk, g_reset : clock, async active-high reset
//   tick_en        : count enable; 0 holds the count
//   clear          : synchronous return of the count to 0 (wins over counting)
//   tick           : mtime increment strobe for this cycle
module core_mtimer_prescale #(
    parameter int PRESCALE = 1
) (
    input  logic g_clk,
    input  logic g_reset,
    input  logic tick_en,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    assign tick = tick_en && (cnt == LAST);

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (tick_en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/core_mtimer.sv
// Machine timer: free-running mtime with prescaler, mtimecmp compare
// interrupt and a software interrupt bit, behind a one-deep MMIO port.
// Ports:
//   g_clk, g_reset        : clock, async active-high reset
//   mmio_req/wen/addr     : access request, direction, byte offset
//   mmio_wdata/strb       : write data and byte strobes
//   mmio_gnt              : request accepted (only when no response pending)
//   mmio_rsp/rdata/err    : response one cycle after grant
//   int_ti                : registered (mtime >= mtimecmp)
//   int_sw                : msip bit
//   tick_en               : 0 freezes mtime and the prescaler
//
// state       | meaning
// MTIMER_IDLE | ready, grant follows request
// MTIMER_RESP | response on the bus, no new grant
module core_mtimer
    import core_common::*;
#(
    parameter int PRESCALE = 1,
    parameter int XLEN     = 64
) (
    input  logic            g_clk,
    input  logic            g_reset,
    input  logic            mmio_req,
    input  logic            mmio_wen,
    input  logic [4:0]      mmio_addr,
    input  logic [XLEN-1:0] mmio_wdata,
    input  logic [7:0]      mmio_strb,
    output logic            mmio_gnt,
    output logic            mmio_rsp,
    output logic [XLEN-1:0] mmio_rdata,
    output logic            mmio_err,
    output logic            int_ti,
    output logic            int_sw,
    input  logic            tick_en
);

    mtimer_state_t   state, state_nxt;
    logic [XLEN-1:0] mtime, mtimecmp, rd_val;
    logic            msip;
    logic            tick, addr_err, wr_ok;
    logic            wr_mtime, wr_cmp, wr_msip;

    function automatic logic [XLEN-1:0] merge_bytes(
        input logic [XLEN-1:0] old_val,
        input logic [XLEN-1:0] new_val,
        input logic [7:0]      strb
    );
        logic [XLEN-1:0] res;
        res = old_val;
        for (int b = 0; b < XLEN / 8; b++) begin
            if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return res;
    endfunction

    assign addr_err = (mmio_addr[2:0] != 3'b000) || (mmio_addr == MTIMER_ADDR_RSVD);
    assign wr_ok    = mmio_gnt && mmio_wen && !addr_err;
    assign wr_mtime = wr_ok && (mmio_addr == MTIMER_ADDR_MTIME);
    assign wr_cmp   = wr_ok && (mmio_addr == MTIMER_ADDR_MTIMECMP);
    assign wr_msip  = wr_ok && (mmio_addr == MTIMER_ADDR_MSIP) && mmio_strb[0];
    assign int_sw   = msip;

    core_mtimer_prescale #(.PRESCALE(PRESCALE)) u_prescale (
        .g_clk   (g_clk),
        .g_reset (g_reset),
        .tick_en (tick_en),
        .clear   (wr_mtime),
        .tick    (tick)
    );

    // Grant is masked during reset so it reads 0 while reset is held.
    always_comb begin
        state_nxt = state;
        mmio_gnt  = 1'b0;
        case (state)
            MTIMER_IDLE: begin
                mmio_gnt = mmio_req && !g_reset;
                if (mmio_req) state_nxt = MTIMER_RESP;
            end
            MTIMER_RESP: state_nxt = MTIMER_IDLE;
            default:     state_nxt = MTIMER_IDLE;
        endcase
    end

    always_comb begin
        rd_val = '0;
        if (!mmio_wen && !addr_err) begin
            case (mmio_addr)
                MTIMER_ADDR_MTIME:    rd_val = mtime;
                MTIMER_ADDR_MTIMECMP: rd_val = mtimecmp;
                MTIMER_ADDR_MSIP:     rd_val = {{(XLEN-1){1'b0}}, msip};
                default:              rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state      <= MTIMER_IDLE;
            mtime      <= '0;
            mtimecmp   <= '1;
            msip       <= 1'b0;
            mmio_rsp   <= 1'b0;
            mmio_err   <= 1'b0;
            mmio_rdata <= '0;
            int_ti     <= 1'b0;
        end else begin
            state      <= state_nxt;
            mmio_rsp   <= mmio_gnt;
            mmio_err   <= mmio_gnt && addr_err;
            mmio_rdata <= mmio_gnt ? rd_val : '0;

            // A write merges into the pre-increment value; the tick is dropped.
            if (wr_mtime)  mtime <= merge_bytes(mtime, mmio_wdata, mmio_strb);
            else if (tick) mtime <= mtime + XLEN'(1);

            if (wr_cmp)  mtimecmp <= merge_bytes(mtimecmp, mmio_wdata, mmio_strb);
            if (wr_msip) msip     <= mmio_wdata[0];

            // Compares the registered values, so it trails them by one cycle.
            int_ti <= (mtime >= mtimecmp);
        end
    end

endmodule
